// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one sram-like port (req/addr_ok/data_ok) between the
// instruction fetch requester and the data requester.
// - Address phase: fixed data-over-inst priority, grant frozen while the memory
//   stalls an issued request (lock), zero added latency.
// - Outstanding transactions: an in-order owner-ID FIFO of depth OUTST routes each
//   data_ok/rdata back to the side that issued it.
// Optional macro ARB_ROUND_ROBIN_EN: when both sides request and no lock is held,
//   grant the side that did not win the last accepted handshake.
module sram_req_arbiter #(
  parameter int OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(OUTST + 1);
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          owner_reg [OUTST];   // 0 = inst, 1 = data
  logic          lock_reg;
  logic          lock_sel_reg;        // side frozen by the lock
`ifdef ARB_ROUND_ROBIN_EN
  logic          rr_last_reg;         // side that won the last accepted handshake
`endif

  logic sel_data;
  logic sel_req;
  logic full;
  logic accept;
  logic resp;
  logic head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(OUTST - 1)) return '0;
    else return p + PW'(1);
  endfunction

  // Requester selection: a held lock wins, otherwise priority (or round robin).
  always_comb begin
    sel_data = data_req;
`ifdef ARB_ROUND_ROBIN_EN
    if (lock_reg)
      sel_data = lock_sel_reg;
    else if (data_req && inst_req)
      sel_data = ~rr_last_reg;
`else
    if (lock_reg)
      sel_data = lock_sel_reg;
`endif
  end

  // Memory request path and address-phase acknowledgements.
  always_comb begin
    sel_req      = sel_data ? data_req : inst_req;
    // Full check uses the registered count: a pop this cycle frees a slot next cycle.
    full         = (count_reg == CW'(OUTST));
    mem_req      = sel_req & ~full;
    mem_wr       = sel_data & data_wr;
    mem_wstrb    = mem_wr ? data_wstrb : 4'h0;
    mem_addr     = sel_data ? data_addr : inst_addr;
    mem_wdata    = sel_data ? data_wdata : 32'h0;
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & ~sel_data;
    data_addr_ok = accept & sel_data;
  end

  // Response routing by FIFO head owner; responses with nothing outstanding are dropped.
  always_comb begin
    resp         = mem_data_ok & (count_reg != '0);
    head_data    = owner_reg[rd_ptr_reg];
    inst_data_ok = resp & ~head_data;
    data_data_ok = resp & head_data;
    inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
    data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    count_next   = count_reg + CW'(accept) - CW'(resp);
  end

  // Owner-ID storage, one register per FIFO slot written on accept.
  genvar gi;
  generate
    for (gi = 0; gi < OUTST; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (!resetn)
          owner_reg[gi] <= 1'b0;
        else if (accept && (wr_ptr_reg == PW'(gi)))
          owner_reg[gi] <= sel_data;
      end
    end
  endgenerate

  // FIFO pointers, occupancy count and the address-phase lock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      lock_reg     <= 1'b0;
      lock_sel_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (resp)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (mem_req && !mem_addr_ok) begin
        lock_reg     <= 1'b1;
        lock_sel_reg <= sel_data;
      end else if (accept) begin
        lock_reg <= 1'b0;
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the winner of each accepted handshake (reset points at inst).
  always_ff @(posedge clk) begin
    if (!resetn)
      rr_last_reg <= 1'b0;
    else if (accept)
      rr_last_reg <= sel_data;
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed testbench for sram_req_arbiter (OUTST = 2). Inputs change 1 ns after
// the rising edge; combinational outputs are checked 2 ns later, well before
// the next edge.
module tb_sram_req_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTST(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // Reset state: no requests -> every req/ok output is 0
    nxt(); settle();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {30'h0, inst_data_ok, data_data_ok}, 0);
    $display("txn reset idle: mem_req=%0b", mem_req);

    // Test 1: data_req held through reset, first grant to data
    data_req = 1'b1; data_addr = 32'h100; data_wstrb = 4'hF;
    nxt(); nxt();
    resetn = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1;
    settle();
    chk("t1_mem_req", 32'(mem_req), 1);
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_data_addr_ok", 32'(data_addr_ok), 1);
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("t1_read_wstrb", 32'(mem_wstrb), 0);
    $display("txn t1 grant: addr=0x%08h data_addr_ok=%0b", mem_addr, data_addr_ok);

    // Test 2: second accept (data with fixed priority, inst with round robin), then full
    nxt(); data_addr = 32'h104; settle();
    chk("t2_second_data_ok", 32'(data_addr_ok), RR ? 0 : 1);
    chk("t2_second_inst_ok", 32'(inst_addr_ok), RR ? 1 : 0);
    chk("t2_second_addr", mem_addr, RR ? 32'h1c00_0000 : 32'h104);
    $display("txn t2 second grant: addr=0x%08h", mem_addr);
    nxt(); settle();
    chk("t2_full_mem_req", 32'(mem_req), 0);
    chk("t2_full_addr_ok", {30'h0, inst_addr_ok, data_addr_ok}, 0);
    nxt(); settle();
    chk("t2_full_mem_req2", 32'(mem_req), 0);
    nxt(); inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h11; settle();
    chk("t2_rsp1_data_ok", 32'(data_data_ok), 1);
    chk("t2_rsp1_rdata", data_rdata, 32'h11);
    chk("t2_rsp1_inst_ok", 32'(inst_data_ok), 0);
    $display("txn t2 rsp1: data_data_ok=%0b rdata=0x%08h", data_data_ok, data_rdata);
    nxt(); mem_rdata = 32'h22; settle();
    chk("t2_rsp2_data_ok", 32'(data_data_ok), RR ? 0 : 1);
    chk("t2_rsp2_inst_ok", 32'(inst_data_ok), RR ? 1 : 0);
    chk("t2_rsp2_rdata", RR ? inst_rdata : data_rdata, 32'h22);
    $display("txn t2 rsp2: inst_ok=%0b data_ok=%0b", inst_data_ok, data_data_ok);
    nxt(); mem_data_ok = 1'b0; settle();
    chk("idle_mem_req", 32'(mem_req), 0);
    chk("idle_data_ok", {30'h0, inst_data_ok, data_data_ok}, 0);

    // Test 3: inst then data, responses routed in order
    inst_req = 1'b1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1'b1; settle();
    chk("t3_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("t3_mem_addr_inst", mem_addr, 32'h1c00_0000);
    $display("txn t3 inst accept: addr=0x%08h", mem_addr);
    nxt(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h100; settle();
    chk("t3_data_addr_ok", 32'(data_addr_ok), 1);
    chk("t3_mem_addr_data", mem_addr, 32'h100);
    $display("txn t3 data accept: addr=0x%08h", mem_addr);
    nxt(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA; settle();
    chk("t3_inst_data_ok", 32'(inst_data_ok), 1);
    chk("t3_inst_rdata", inst_rdata, 32'hAAAA);
    chk("t3_data_quiet", {31'h0, data_data_ok}, 0);
    chk("t3_data_rdata_zero", data_rdata, 0);
    $display("txn t3 rsp inst: rdata=0x%08h", inst_rdata);
    nxt(); mem_rdata = 32'h5555; settle();
    chk("t3_data_data_ok", 32'(data_data_ok), 1);
    chk("t3_data_rdata", data_rdata, 32'h5555);
    chk("t3_inst_rdata_zero", inst_rdata, 0);
    $display("txn t3 rsp data: rdata=0x%08h", data_rdata);
    nxt(); mem_data_ok = 1'b0;

    // Test 4: memory stalls an inst request while data_req rises
    inst_req = 1'b1; inst_addr = 32'h1c00_0040; settle();
    chk("t4_stall_req", 32'(mem_req), 1);
    chk("t4_stall_inst_ok", 32'(inst_addr_ok), 0);
    nxt(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3; data_addr = 32'h300;
    data_wdata = 32'hDEAD; settle();
    chk("t4_lock_addr", mem_addr, 32'h1c00_0040);
    chk("t4_lock_wr", {27'h0, mem_wr, mem_wstrb}, 0);
    chk("t4_lock_ok", {30'h0, inst_addr_ok, data_addr_ok}, 0);
    nxt(); settle();
    chk("t4_lock_addr3", mem_addr, 32'h1c00_0040);
    nxt(); mem_addr_ok = 1'b1; settle();
    chk("t4_hs_inst_ok", 32'(inst_addr_ok), 1);
    chk("t4_hs_data_ok", 32'(data_addr_ok), 0);
    chk("t4_hs_addr", mem_addr, 32'h1c00_0040);
    $display("txn t4 inst handshake after stall: addr=0x%08h", mem_addr);
    nxt(); inst_req = 1'b0; settle();
    chk("t4_data_addr", mem_addr, 32'h300);
    chk("t4_data_wr", {27'h0, mem_wr, mem_wstrb}, 32'h13);
    chk("t4_data_wdata", mem_wdata, 32'hDEAD);
    chk("t4_data_ok", 32'(data_addr_ok), 1);
    $display("txn t4 data write: addr=0x%08h wstrb=%h", mem_addr, mem_wstrb);
    nxt(); data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h77; settle();
    chk("t4_rsp_inst", {30'h0, inst_data_ok, data_data_ok}, 2);
    chk("t4_rsp_inst_rdata", inst_rdata, 32'h77);
    nxt(); mem_rdata = 32'h0; settle();
    chk("t4_rsp_wdone", {30'h0, inst_data_ok, data_data_ok}, 1);
    $display("txn t4 write done: data_data_ok=%0b", data_data_ok);

    // Test 5: spurious responses with nothing outstanding
    nxt(); mem_rdata = 32'hBAD; settle();
    chk("t5_spur1", {30'h0, inst_data_ok, data_data_ok}, 0);
    chk("t5_spur_rdata", inst_rdata | data_rdata, 0);
    nxt(); settle();
    chk("t5_spur2", {30'h0, inst_data_ok, data_data_ok}, 0);
    $display("txn t5 spurious data_ok ignored");
    nxt(); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h400; mem_addr_ok = 1'b1; settle();
    chk("t5_fill1", 32'(data_addr_ok), 1);
    nxt(); settle();
    chk("t5_fill2", 32'(data_addr_ok), 1);
    nxt(); mem_data_ok = 1'b1; mem_rdata = 32'h99; settle();
    chk("t5_full_pop_req", 32'(mem_req), 0);
    chk("t5_full_pop_ok", 32'(data_addr_ok), 0);
    chk("t5_full_pop_rsp", 32'(data_data_ok), 1);
    $display("txn t5 full with same-cycle pop: mem_req=%0b", mem_req);
    nxt(); mem_data_ok = 1'b0; settle();
    chk("t5_after_pop_req", 32'(mem_req), 1);
    chk("t5_after_pop_ok", 32'(data_addr_ok), 1);
    nxt(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
    chk("t5_drain1", 32'(data_data_ok), 1);
    nxt(); settle();
    chk("t5_drain2", 32'(data_data_ok), 1);
    nxt(); settle();
    chk("t5_drained", 32'(data_data_ok), 0);
    mem_data_ok = 1'b0;

    // Test 6: reset, then both requesters continuously with a response every cycle
    resetn = 1'b0; nxt();
    resetn = 1'b1; inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1c00_0100;
    data_addr = 32'h500; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_data;
      logic prev_data;
      mem_rdata = 32'h600 + 32'(k);
      exp_data  = RR ? ((k % 2) == 0) : 1'b1;
      prev_data = RR ? ((k % 2) == 1) : 1'b1;
      settle();
      chk($sformatf("t6_grant_data_%0d", k), 32'(data_addr_ok), 32'(exp_data));
      chk($sformatf("t6_grant_inst_%0d", k), 32'(inst_addr_ok), 32'(!exp_data));
      if (k == 0) begin
        chk("t6_rsp_empty", {30'h0, inst_data_ok, data_data_ok}, 0);
      end else begin
        chk($sformatf("t6_rsp_%0d", k), {30'h0, inst_data_ok, data_data_ok},
            prev_data ? 32'h1 : 32'h2);
        chk($sformatf("t6_rdata_%0d", k), inst_rdata | data_rdata, 32'h600 + 32'(k));
      end
      $display("txn t6 cycle %0d: inst_addr_ok=%0b data_addr_ok=%0b inst_data_ok=%0b data_data_ok=%0b",
               k, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
